// File: rtl/wbq_pkg.sv
// wbq_pkg: shared widths and queued-entry type for the writeback queue.
package wbq_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] ZERO_REG = '0;
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbq_entry_t;
endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match: finds the youngest valid queued entry whose address matches a lookup.
module wbq_fwd_match
    import wbq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wbq_entry_t                 entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head,
    input  logic [ADDR_W-1:0]          addr,
    output logic                       hit,
    output logic [DATA_W-1:0]          data
);
    localparam int PW = $clog2(DEPTH);

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[head + PW'(i)].valid && entries[head + PW'(i)].addr == addr && addr != ZERO_REG) begin
                hit  = 1'b1;
                data = entries[head + PW'(i)].data;
            end
        end
    end
endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: buffers writeback results in an in-order FIFO, drains them into
// the register file write port and forwards still-queued values to the ID stage.
module wb_write_queue
    import wbq_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = wbq_pkg::ADDR_W,
    parameter int DATA_W = wbq_pkg::DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     hold,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [ADDR_W-1:0]        fwd_addr_a,
    output logic                     fwd_hit_a,
    output logic [DATA_W-1:0]        fwd_data_a,
    input  logic [ADDR_W-1:0]        fwd_addr_b,
    output logic                     fwd_hit_b,
    output logic [DATA_W-1:0]        fwd_data_b,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wbq_entry_t      q [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic            enq;

    // in_ready is forced low during reset so nothing is handed over while flushing.
    assign in_ready = reset && (count != CW'(DEPTH));
    assign enq      = in_valid && in_ready && (in_addr != ZERO_REG);
    assign wr_en    = (count != '0) && !hold;
    assign wr_addr  = q[head].valid ? q[head].addr : '0;
    assign wr_data  = q[head].valid ? q[head].data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
        end else begin
            if (enq) begin
                q[tail] <= '{valid: 1'b1, addr: in_addr, data: in_data};
                tail    <= tail + PW'(1);
            end
            if (wr_en) begin
                q[head].valid <= 1'b0;
                head          <= head + PW'(1);
            end
            count <= count + CW'(enq) - CW'(wr_en);
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_a (
        .entries (q),
        .head    (head),
        .addr    (fwd_addr_a),
        .hit     (fwd_hit_a),
        .data    (fwd_data_a)
    );

    wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_b (
        .entries (q),
        .head    (head),
        .addr    (fwd_addr_b),
        .hit     (fwd_hit_b),
        .data    (fwd_data_b)
    );
endmodule
